// File: rtl/y86_decode_execute_pc.sv
// Sequential Y86-64 decode, register file, execute, condition codes and next-PC selection.
// Everything up to new_pc is combinational; registers and CC commit on the rising clock edge.
module y86_decode_execute_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cnd,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic [63:0] new_pc,
    output logic [63:0] reg_arr0,
    output logic [63:0] reg_arr1,
    output logic [63:0] reg_arr2,
    output logic [63:0] reg_arr3,
    output logic [63:0] reg_arr4,
    output logic [63:0] reg_arr5,
    output logic [63:0] reg_arr6,
    output logic [63:0] reg_arr7,
    output logic [63:0] reg_arr8,
    output logic [63:0] reg_arr9,
    output logic [63:0] reg_arr10,
    output logic [63:0] reg_arr11,
    output logic [63:0] reg_arr12,
    output logic [63:0] reg_arr13,
    output logic [63:0] reg_arr14
);

    localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF, R_RSP = 4'h4;
    localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_XOR = 2'd3;

    logic [63:0]        regs [0:14];
    logic [3:0]         src_a, src_b, dst_e, dst_m;
    logic signed [63:0] alu_a, alu_b, alu_e;
    logic [1:0]         alu_fn;
    logic               zf_n, sf_n, of_n;

    function automatic logic cond_eval(input logic [3:0] fn, input logic z, input logic s,
                                       input logic o);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return (s ^ o) | z;
            4'd2:    return s ^ o;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !(s ^ o);
            4'd6:    return !(s ^ o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    assign cnd = cond_eval(ifun, zf, sf, of);

    // Decode: register specifiers and operand reads
    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
            I_RET, I_POPQ:                      src_a = R_RSP;
            default:                            src_a = R_NONE;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         src_b = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    src_b = R_RSP;
            default:                           src_b = R_NONE;
        endcase
        case (icode)
            I_IRMOVQ, I_OPQ:                   dst_e = rB;
            I_RRMOVQ:                          dst_e = cnd ? rB : R_NONE;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = R_RSP;
            default:                           dst_e = R_NONE;
        endcase
        if (icode == I_MRMOVQ || icode == I_POPQ)
            dst_m = rA;
    end

    assign valA = (src_a == R_NONE) ? 64'd0 : regs[src_a];
    assign valB = (src_b == R_NONE) ? 64'd0 : regs[src_b];

    // Execute: operand selection, ALU and next condition codes
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            I_RRMOVQ, I_OPQ:              alu_a = $signed(valA);
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = $signed(valC);
            I_CALL, I_PUSHQ:              alu_a = -64'sd8;
            I_RET, I_POPQ:                alu_a = 64'sd8;
            default:                      alu_a = '0;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = $signed(valB);
            default:                                                  alu_b = '0;
        endcase
        alu_fn = (icode == I_OPQ && ifun <= 4'd3) ? ifun[1:0] : ALU_ADD;
        case (alu_fn)
            ALU_SUB: alu_e = alu_b - alu_a;
            ALU_AND: alu_e = alu_b & alu_a;
            ALU_XOR: alu_e = alu_b ^ alu_a;
            default: alu_e = alu_b + alu_a;
        endcase
        zf_n = (alu_e == 64'sd0);
        sf_n = alu_e[63];
        case (alu_fn)
            ALU_ADD: of_n = (alu_a[63] == alu_b[63]) && (alu_e[63] != alu_a[63]);
            ALU_SUB: of_n = (alu_a[63] != alu_b[63]) && (alu_e[63] != alu_b[63]);
            default: of_n = 1'b0;
        endcase
    end

    assign valE = $unsigned(alu_e);

    always_comb begin
        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   new_pc = cnd ? valC : valP;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

    // Write-back: the later valM write wins when dst_e == dst_m (popq %rsp)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
            zf <= 1'b1;
            sf <= 1'b0;
            of <= 1'b0;
        end else begin
            if (dst_e != R_NONE)
                regs[dst_e] <= valE;
            if (dst_m != R_NONE)
                regs[dst_m] <= valM;
            if (icode == I_OPQ) begin
                zf <= zf_n;
                sf <= sf_n;
                of <= of_n;
            end
        end
    end

    assign reg_arr0  = regs[0];
    assign reg_arr1  = regs[1];
    assign reg_arr2  = regs[2];
    assign reg_arr3  = regs[3];
    assign reg_arr4  = regs[4];
    assign reg_arr5  = regs[5];
    assign reg_arr6  = regs[6];
    assign reg_arr7  = regs[7];
    assign reg_arr8  = regs[8];
    assign reg_arr9  = regs[9];
    assign reg_arr10 = regs[10];
    assign reg_arr11 = regs[11];
    assign reg_arr12 = regs[12];
    assign reg_arr13 = regs[13];
    assign reg_arr14 = regs[14];

endmodule

// File: tb/tb_y86_decode_execute_pc.sv
// Scoreboard bench for y86_decode_execute_pc: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_y86_decode_execute_pc;

    logic        clk, rst;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valM;
    logic [63:0] valA, valB, valE, new_pc;
    logic        cnd, zf, sf, of;
    logic [63:0] reg_arr0, reg_arr1, reg_arr2, reg_arr3, reg_arr4, reg_arr5, reg_arr6, reg_arr7;
    logic [63:0] reg_arr8, reg_arr9, reg_arr10, reg_arr11, reg_arr12, reg_arr13, reg_arr14;
    logic [63:0] ra [0:14];

    y86_decode_execute_pc dut (
        .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .valM(valM), .valA(valA), .valB(valB), .valE(valE),
        .cnd(cnd), .zf(zf), .sf(sf), .of(of), .new_pc(new_pc),
        .reg_arr0(reg_arr0), .reg_arr1(reg_arr1), .reg_arr2(reg_arr2), .reg_arr3(reg_arr3),
        .reg_arr4(reg_arr4), .reg_arr5(reg_arr5), .reg_arr6(reg_arr6), .reg_arr7(reg_arr7),
        .reg_arr8(reg_arr8), .reg_arr9(reg_arr9), .reg_arr10(reg_arr10), .reg_arr11(reg_arr11),
        .reg_arr12(reg_arr12), .reg_arr13(reg_arr13), .reg_arr14(reg_arr14)
    );

    assign ra[0] = reg_arr0;   assign ra[1] = reg_arr1;   assign ra[2] = reg_arr2;
    assign ra[3] = reg_arr3;   assign ra[4] = reg_arr4;   assign ra[5] = reg_arr5;
    assign ra[6] = reg_arr6;   assign ra[7] = reg_arr7;   assign ra[8] = reg_arr8;
    assign ra[9] = reg_arr9;   assign ra[10] = reg_arr10; assign ra[11] = reg_arr11;
    assign ra[12] = reg_arr12; assign ra[13] = reg_arr13; assign ra[14] = reg_arr14;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_VALA = 0, S_VALB = 1, S_VALE = 2, S_CND = 3, S_ZF = 4, S_SF = 5;
    localparam int S_OF = 6, S_PC = 7, S_REG = 10;
    localparam logic [3:0] RN = 4'hF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    typedef struct {
        int          id;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [63:0] actual(input int id);
        case (id)
            S_VALA:  return valA;
            S_VALB:  return valB;
            S_VALE:  return valE;
            S_CND:   return {63'd0, cnd};
            S_ZF:    return {63'd0, zf};
            S_SF:    return {63'd0, sf};
            S_OF:    return {63'd0, of};
            S_PC:    return new_pc;
            default: return ra[id - S_REG];
        endcase
    endfunction

    task automatic chk(input int id, input logic [63:0] e, input string n);
        chk_t c;
        c.id = id;
        c.exp = e;
        c.name = n;
        sb.push_back(c);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] c, input logic [63:0] p,
                         input logic [63:0] m);
        @(posedge clk);
        #1;
        icode = ic; ifun = fn; rA = a; rB = b; valC = c; valP = p; valM = m;
    endtask

    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [63:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            act = actual(c.id);
            n_total++;
            if (act === c.exp)
                n_pass++;
            else
                $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
    end

    initial begin
        rst = 1'b1;
        icode = 4'h1; ifun = 4'h0; rA = RN; rB = RN; valC = '0; valP = '0; valM = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Dirty state, then asynchronous reset in the first half of a cycle
        drive(4'h3, 4'h0, RN, 4'h0, 64'h1234, 64'h0, 64'h0);
        chk(S_VALE, 64'h1234, "irmovq_vale");
        drive(4'h6, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
        chk(S_VALA, 64'h1234, "addq_vala");
        chk(S_VALB, 64'h1234, "addq_valb");
        chk(S_VALE, 64'h2468, "addq_vale");
        drive(4'h7, 4'h3, RN, RN, 64'h100, 64'h20, 64'h0);
        chk(S_REG + 0, 64'h2468, "pre_rst_rax");
        chk(S_ZF, 64'd0, "pre_rst_zf");
        chk(S_CND, 64'd0, "pre_rst_je_cnd");
        chk(S_PC, 64'h20, "pre_rst_je_pc");
        drive(4'h7, 4'h3, RN, RN, 64'h100, 64'h20, 64'h0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 15; i++)
            chk(S_REG + i, 64'd0, $sformatf("rst_reg%0d", i));
        chk(S_ZF, 64'd1, "rst_zf");
        chk(S_SF, 64'd0, "rst_sf");
        chk(S_OF, 64'd0, "rst_of");
        chk(S_CND, 64'd1, "rst_je_cnd");
        chk(S_PC, 64'h100, "rst_je_pc");
        @(negedge clk);
        #1 rst = 1'b0;

        // irmovq + andq + subq to zero
        drive(4'h3, 4'h0, RN, 4'h0, 64'd5, 64'h0, 64'h0);
        chk(S_VALE, 64'd5, "irmovq5_vale");
        drive(4'h3, 4'h0, RN, 4'h3, 64'd5, 64'h0, 64'h0);
        chk(S_REG + 0, 64'd5, "rax_5");
        drive(4'h6, 4'h2, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
        chk(S_REG + 3, 64'd5, "rbx_5");
        chk(S_VALE, 64'd5, "andq_vale");
        drive(4'h6, 4'h1, 4'h0, 4'h3, 64'h0, 64'h0, 64'h0);
        chk(S_ZF, 64'd0, "andq_zf");
        chk(S_VALE, 64'd0, "subq_vale");
        drive(4'h3, 4'h0, RN, 4'h0, MAXP, 64'h0, 64'h0);
        chk(S_REG + 3, 64'd0, "subq_rbx");
        chk(S_ZF, 64'd1, "subq_zf");

        // Signed overflow on add and sub, then conditional jumps
        drive(4'h3, 4'h0, RN, 4'h3, 64'd1, 64'h0, 64'h0);
        chk(S_VALE, 64'd1, "irmovq1_vale");
        drive(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h0, 64'h0);
        chk(S_VALA, MAXP, "ovf_vala");
        chk(S_VALB, 64'd1, "ovf_valb");
        chk(S_VALE, MINN, "ovf_vale");
        drive(4'h7, 4'h2, RN, RN, 64'h300, 64'h50, 64'h0);
        chk(S_ZF, 64'd0, "ovf_zf");
        chk(S_SF, 64'd1, "ovf_sf");
        chk(S_OF, 64'd1, "ovf_of");
        chk(S_REG + 3, MINN, "ovf_rbx");
        chk(S_CND, 64'd0, "jl_cnd");
        chk(S_PC, 64'h50, "jl_pc");
        drive(4'h6, 4'h1, 4'h0, 4'h3, 64'h0, 64'h0, 64'h0);
        chk(S_VALE, 64'd1, "subovf_vale");
        drive(4'h7, 4'h5, RN, RN, 64'h300, 64'h58, 64'h0);
        chk(S_OF, 64'd1, "subovf_of");
        chk(S_SF, 64'd0, "subovf_sf");
        chk(S_CND, 64'd0, "jge_cnd");
        chk(S_PC, 64'h58, "jge_pc");
        drive(4'h7, 4'h1, RN, RN, 64'h300, 64'h60, 64'h0);
        chk(S_CND, 64'd1, "jle_cnd");
        chk(S_PC, 64'h300, "jle_pc");
        drive(4'h6, 4'h3, 4'h3, 4'h3, 64'h0, 64'h0, 64'h0);
        chk(S_VALE, 64'd0, "xorq_vale");
        drive(4'h7, 4'h6, RN, RN, 64'h300, 64'h68, 64'h0);
        chk(S_OF, 64'd0, "xorq_of");
        chk(S_ZF, 64'd1, "xorq_zf");
        chk(S_CND, 64'd0, "jg_cnd");
        chk(S_PC, 64'h68, "jg_pc");
        drive(4'h7, 4'h7, RN, RN, 64'h300, 64'h70, 64'h0);
        chk(S_CND, 64'd0, "jbadfn_cnd");
        chk(S_PC, 64'h70, "jbadfn_pc");
        drive(4'h7, 4'h0, RN, RN, 64'h300, 64'h78, 64'h0);
        chk(S_CND, 64'd1, "jmp_cnd");
        chk(S_PC, 64'h300, "jmp_pc");

        // Stack: pushq, call, ret
        drive(4'h3, 4'h0, RN, 4'h4, 64'h200, 64'h0, 64'h0);
        drive(4'hA, 4'h0, 4'h0, RN, 64'h0, 64'h80, 64'h0);
        chk(S_VALA, MAXP, "push_vala");
        chk(S_VALB, 64'h200, "push_valb");
        chk(S_VALE, 64'h1F8, "push_vale");
        chk(S_PC, 64'h80, "push_pc");
        drive(4'h8, 4'h0, RN, RN, 64'h40, 64'h90, 64'h0);
        chk(S_REG + 4, 64'h1F8, "push_rsp");
        chk(S_PC, 64'h40, "call_pc");
        chk(S_VALE, 64'h1F0, "call_vale");
        drive(4'h9, 4'h0, RN, RN, 64'h0, 64'h98, 64'h29);
        chk(S_REG + 4, 64'h1F0, "call_rsp");
        chk(S_VALA, 64'h1F0, "ret_vala");
        chk(S_PC, 64'h29, "ret_pc");
        chk(S_VALE, 64'h1F8, "ret_vale");
        drive(4'h3, 4'h0, RN, 4'h4, 64'h100, 64'h0, 64'h0);
        chk(S_REG + 4, 64'h1F8, "ret_rsp");

        // popq %rsp (valM wins), then ordinary popq
        drive(4'hB, 4'h0, 4'h4, RN, 64'h0, 64'h0, 64'h55);
        chk(S_VALA, 64'h100, "poprsp_vala");
        chk(S_VALB, 64'h100, "poprsp_valb");
        chk(S_VALE, 64'h108, "poprsp_vale");
        drive(4'hB, 4'h0, 4'h2, RN, 64'h0, 64'h0, 64'h77);
        chk(S_REG + 4, 64'h55, "poprsp_rsp");
        chk(S_VALE, 64'h5D, "poprdx_vale");
        drive(4'h3, 4'h0, RN, 4'h1, 64'h33, 64'h0, 64'h0);
        chk(S_REG + 2, 64'h77, "poprdx_rdx");
        chk(S_REG + 4, 64'h5D, "poprdx_rsp");

        // cmovne with ZF=1, then after a nonzero OPq
        drive(4'h2, 4'h4, 4'h0, 4'h1, 64'h0, 64'h0, 64'h0);
        chk(S_CND, 64'd0, "cmovne0_cnd");
        chk(S_VALE, MAXP, "cmovne0_vale");
        drive(4'h6, 4'h2, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
        chk(S_REG + 1, 64'h33, "cmovne0_rcx");
        drive(4'h2, 4'h4, 4'h0, 4'h1, 64'h0, 64'h0, 64'h0);
        chk(S_ZF, 64'd0, "andq2_zf");
        chk(S_CND, 64'd1, "cmovne1_cnd");

        // Invalid icode, rmmovq, halt: no register writes
        drive(4'hC, 4'h0, 4'h0, 4'h1, 64'h500, 64'hA0, 64'h99);
        chk(S_REG + 1, MAXP, "cmovne1_rcx");
        chk(S_PC, 64'hA0, "invalid_pc");
        drive(4'h4, 4'h0, 4'h0, 4'h3, 64'h10, 64'hA8, 64'h0);
        chk(S_REG + 0, MAXP, "invalid_rax");
        chk(S_REG + 1, MAXP, "invalid_rcx");
        chk(S_VALA, MAXP, "rmmovq_vala");
        chk(S_VALE, 64'h10, "rmmovq_vale");
        drive(4'h0, 4'h0, 4'h0, 4'h1, 64'h600, 64'hB0, 64'h0);
        chk(S_REG + 3, 64'd0, "rmmovq_rbx");
        chk(S_PC, 64'hB0, "halt_pc");
        chk(S_VALE, 64'd0, "halt_vale");
        drive(4'h1, 4'h0, RN, RN, 64'h0, 64'hB8, 64'h0);
        chk(S_REG + 1, MAXP, "halt_rcx");
        chk(S_PC, 64'hB8, "nop_pc");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
